// File: rtl/izh_inacc_bank.sv
// Multi-neuron input accumulator bank: leak/exc/inh/clear events plus whole-bank leak and clear sweeps.
// Latency: an event accepted at edge k is written back and reported on out_* at edge k+1; sweeps write one index per cycle.
// Backpressure: ev_ready is low in reset, during a sweep, and while a sweep request is present. Optional build macro: IZH_INACC_OVFL_CLR_EN.
module izh_inacc_bank #(
  parameter int ACC_DEPTH = 11,
  parameter int N_NEUR    = 16,
  parameter int W_WIDTH   = 3,
  localparam int AW       = $clog2(N_NEUR)
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [6:0]           param_leak_str,
  input  logic                 param_leak_en,
  input  logic [2:0]           param_fi_sel,
  input  logic                 ev_valid,
  output logic                 ev_ready,
  input  logic [1:0]           ev_type,
  input  logic [AW-1:0]        ev_addr,
  input  logic [W_WIDTH-1:0]   ev_weight,
  input  logic                 leak_all,
  input  logic                 clr_all,
  output logic                 out_valid,
  output logic [AW-1:0]        out_addr,
  output logic [ACC_DEPTH-1:0] out_state,
  output logic                 ovfl_leak,
  output logic                 ovfl_exc,
  output logic                 ovfl_inh,
  input  logic [AW-1:0]        dbg_addr,
  output logic [ACC_DEPTH-1:0] dbg_state
);

  localparam logic [1:0] OP_LEAK = 2'd0;
  localparam logic [1:0] OP_EXC  = 2'd1;
  localparam logic [1:0] OP_INH  = 2'd2;
  localparam logic [1:0] OP_CLR  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLR   = 2'd1,
    ST_LEAK  = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;

  logic [ACC_DEPTH-1:0] acc [N_NEUR];

  // S1 holds the one accepted event that executes in the following cycle
  logic               s1_vld;
  logic [1:0]         s1_type;
  logic [AW-1:0]      s1_addr;
  logic [W_WIDTH-1:0] s1_weight;

  logic               op_vld;
  logic               op_out;
  logic [1:0]         op_type;
  logic [AW-1:0]      op_addr;
  logic [W_WIDTH-1:0] op_w;

  logic [ACC_DEPTH-1:0] cur;
  logic [ACC_DEPTH-1:0] nxt_raw;
  logic [ACC_DEPTH-1:0] nxt;
  logic [ACC_DEPTH-1:0] leak_ext;
  logic [ACC_DEPTH-1:0] w_ext;
  int                   fib;
  logic                 bit_cur;
  logic                 bit_nxt;
  logic                 ovfl;
`ifdef IZH_INACC_OVFL_CLR_EN
  logic [ACC_DEPTH-1:0] clr_mask;
`endif

  logic accept;

  // New work is only taken while idle and no sweep is being requested
  assign ev_ready  = !RST && (state_q == ST_IDLE) && !leak_all && !clr_all;
  assign accept    = ev_valid && ev_ready;
  assign dbg_state = acc[dbg_addr];

  // Sweep FSM state and index registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Sweep FSM next state: clear wins over leak, requests outside idle are dropped
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      ST_IDLE: begin
        idx_d = '0;
        if (clr_all) begin
          state_d = ST_CLR;
        end else if (leak_all) begin
          state_d = ST_LEAK;
        end
      end
      ST_CLR, ST_LEAK: begin
        idx_d = idx_q + AW'(1);
        if (idx_q == AW'(N_NEUR - 1)) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // Capture an accepted event into S1
  always_ff @(posedge CLK) begin
    if (RST) begin
      s1_vld    <= 1'b0;
      s1_type   <= OP_LEAK;
      s1_addr   <= '0;
      s1_weight <= '0;
    end else begin
      s1_vld <= accept;
      if (accept) begin
        s1_type   <= ev_type;
        s1_addr   <= ev_addr;
        s1_weight <= ev_weight;
      end
    end
  end

  // Pick the operation executing this cycle; a sweep and S1 never overlap
  always_comb begin
    op_vld  = 1'b0;
    op_out  = 1'b0;
    op_type = OP_LEAK;
    op_addr = '0;
    op_w    = '0;
    if (state_q == ST_CLR) begin
      op_vld  = 1'b1;
      op_type = OP_CLR;
      op_addr = idx_q;
    end else if (state_q == ST_LEAK) begin
      op_vld  = 1'b1;
      op_out  = 1'b1;
      op_type = OP_LEAK;
      op_addr = idx_q;
    end else if (s1_vld) begin
      op_vld  = 1'b1;
      op_out  = 1'b1;
      op_type = s1_type;
      op_addr = s1_addr;
      op_w    = s1_weight;
    end
  end

  // Read-modify-write arithmetic and overflow detection at the fan-in bit
  always_comb begin
    cur      = acc[op_addr];
    leak_ext = {{(ACC_DEPTH-7){1'b0}}, param_leak_str};
    w_ext    = {{(ACC_DEPTH-W_WIDTH){1'b0}}, op_w};
    nxt_raw  = cur;
    case (op_type)
      OP_LEAK: nxt_raw = param_leak_en ? (cur - leak_ext) : cur;
      OP_EXC:  nxt_raw = cur + w_ext;
      OP_INH:  nxt_raw = cur - w_ext;
      default: nxt_raw = '0;
    endcase

    fib = 3 + int'(param_fi_sel);
    if (fib > ACC_DEPTH - 1) begin
      fib = ACC_DEPTH - 1;
    end

    bit_cur = 1'b0;
    bit_nxt = 1'b0;
`ifdef IZH_INACC_OVFL_CLR_EN
    clr_mask = '0;
`endif
    for (int i = 0; i < ACC_DEPTH; i++) begin
      if (i == fib) begin
        bit_cur = cur[i];
        bit_nxt = nxt_raw[i];
      end
`ifdef IZH_INACC_OVFL_CLR_EN
      if (i <= fib) begin
        clr_mask[i] = 1'b1;
      end
`endif
    end

    ovfl = (op_type != OP_CLR) && (bit_cur ^ bit_nxt);

`ifdef IZH_INACC_OVFL_CLR_EN
    // Restart the fan-in window: drop everything at and below the overflow bit
    nxt = ovfl ? (nxt_raw & ~clr_mask) : nxt_raw;
`else
    nxt = nxt_raw;
`endif
  end

  // Accumulator write-back; reset discards any in-flight write
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < N_NEUR; i++) begin
        acc[i] <= '0;
      end
    end else if (op_vld) begin
      acc[op_addr] <= nxt;
    end
  end

  // Result reporting, one pulse per reported op
  always_ff @(posedge CLK) begin
    if (RST) begin
      out_valid <= 1'b0;
      out_addr  <= '0;
      out_state <= '0;
      ovfl_leak <= 1'b0;
      ovfl_exc  <= 1'b0;
      ovfl_inh  <= 1'b0;
    end else begin
      out_valid <= op_out;
      ovfl_leak <= op_out && (op_type == OP_LEAK) && ovfl;
      ovfl_exc  <= op_out && (op_type == OP_EXC)  && ovfl;
      ovfl_inh  <= op_out && (op_type == OP_INH)  && ovfl;
      if (op_out) begin
        out_addr  <= op_addr;
        out_state <= nxt;
      end
    end
  end

endmodule

// File: tb/tb_izh_inacc_bank.sv
// Self-checking bench for izh_inacc_bank: directed cases plus randomized traffic against a behavioural model.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// Honours IZH_INACC_OVFL_CLR_EN when computing expected write-back values.
module tb_izh_inacc_bank;

  typedef logic [18:0] pk_t;   // {valid, addr[3:0], state[10:0], ovfl_leak, ovfl_exc, ovfl_inh}

  logic        CLK = 1'b0;
  logic        RST;
  logic [6:0]  param_leak_str;
  logic        param_leak_en;
  logic [2:0]  param_fi_sel;
  logic        ev_valid;
  logic        ev_ready;
  logic [1:0]  ev_type;
  logic [3:0]  ev_addr;
  logic [2:0]  ev_weight;
  logic        leak_all;
  logic        clr_all;
  logic        out_valid;
  logic [3:0]  out_addr;
  logic [10:0] out_state;
  logic        ovfl_leak, ovfl_exc, ovfl_inh;
  logic [3:0]  dbg_addr;
  logic [10:0] dbg_state;

  // 8-bit, two-entry instance for the narrow-accumulator fan-in case
  logic        b_ev_valid, b_ev_ready;
  logic [1:0]  b_ev_type;
  logic [0:0]  b_ev_addr;
  logic [2:0]  b_ev_weight;
  logic        b_out_valid;
  logic [0:0]  b_out_addr;
  logic [7:0]  b_out_state;
  logic        b_ovfl_leak, b_ovfl_exc, b_ovfl_inh;
  logic [0:0]  b_dbg_addr;
  logic [7:0]  b_dbg_state;

  int n_checks = 0;
  int n_pass   = 0;
  int mdl [16];

  izh_inacc_bank #(.ACC_DEPTH(11), .N_NEUR(16), .W_WIDTH(3)) dut (
    .CLK(CLK), .RST(RST),
    .param_leak_str(param_leak_str), .param_leak_en(param_leak_en), .param_fi_sel(param_fi_sel),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_type(ev_type), .ev_addr(ev_addr), .ev_weight(ev_weight),
    .leak_all(leak_all), .clr_all(clr_all),
    .out_valid(out_valid), .out_addr(out_addr), .out_state(out_state),
    .ovfl_leak(ovfl_leak), .ovfl_exc(ovfl_exc), .ovfl_inh(ovfl_inh),
    .dbg_addr(dbg_addr), .dbg_state(dbg_state)
  );

  izh_inacc_bank #(.ACC_DEPTH(8), .N_NEUR(2), .W_WIDTH(3)) dut8 (
    .CLK(CLK), .RST(RST),
    .param_leak_str(param_leak_str), .param_leak_en(param_leak_en), .param_fi_sel(param_fi_sel),
    .ev_valid(b_ev_valid), .ev_ready(b_ev_ready), .ev_type(b_ev_type), .ev_addr(b_ev_addr), .ev_weight(b_ev_weight),
    .leak_all(1'b0), .clr_all(1'b0),
    .out_valid(b_out_valid), .out_addr(b_out_addr), .out_state(b_out_state),
    .ovfl_leak(b_ovfl_leak), .ovfl_exc(b_ovfl_exc), .ovfl_inh(b_ovfl_inh),
    .dbg_addr(b_dbg_addr), .dbg_state(b_dbg_state)
  );

  always #5 CLK = ~CLK;

  // Behavioural reference: one op on a plain integer accumulator of the given width
  function automatic void model_op(input int t, input int s, input int w, input int ls, input bit en,
                                   input int fi, input int depth, output int n, output bit f);
    int mask;
    int fb;
    mask = (1 << depth) - 1;
    case (t)
      0:       n = en ? s - ls : s;
      1:       n = s + w;
      2:       n = s - w;
      default: n = 0;
    endcase
    n  = n & mask;
    fb = 3 + fi;
    if (fb > depth - 1) fb = depth - 1;
    f = (t != 3) && (((s >> fb) & 1) != ((n >> fb) & 1));
`ifdef IZH_INACC_OVFL_CLR_EN
    if (f) n = n & ~((2 << fb) - 1);
`endif
  endfunction

  function automatic pk_t pk(input bit v, input int a, input int s, input bit l, input bit e, input bit i);
    return {v, a[3:0], s[10:0], l, e, i};
  endfunction

  function automatic pk_t obs_now();
    return {out_valid, out_addr, out_state, ovfl_leak, ovfl_exc, ovfl_inh};
  endfunction

  // Drive one event on the main instance and return the reported result
  task automatic issue(input int t, input int a, input int w, output pk_t obs, output logic rdy);
    int n;
    bit f;
    @(negedge CLK);
    ev_valid = 1'b1; ev_type = t[1:0]; ev_addr = a[3:0]; ev_weight = w[2:0];
    rdy = ev_ready;
    model_op(t, mdl[a], w, int'(param_leak_str), param_leak_en, int'(param_fi_sel), 11, n, f);
    mdl[a] = n;
    @(negedge CLK);
    ev_valid = 1'b0;
    @(negedge CLK);
    obs = obs_now();
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b1; ev_valid = 1'b0; b_ev_valid = 1'b0; leak_all = 1'b0; clr_all = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    foreach (mdl[i]) mdl[i] = 0;
  endtask

  task automatic test_reset();
    @(negedge CLK);
    RST = 1'b1; ev_valid = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    n_checks++;
    if ({out_valid, out_state, ovfl_leak, ovfl_exc, ovfl_inh, ev_ready} !== 15'd0)
      $display("FAIL reset_outputs: got valid=%b state=%h flags=%b%b%b ready=%b, want all 0",
               out_valid, out_state, ovfl_leak, ovfl_exc, ovfl_inh, ev_ready);
    else n_pass++;
    ev_valid = 1'b0;
    RST = 1'b0;
    foreach (mdl[i]) mdl[i] = 0;
    @(negedge CLK);
    n_checks++;
    if (ev_ready !== 1'b1) $display("FAIL reset_ready_after: got %b want 1", ev_ready);
    else n_pass++;
    for (int a = 0; a < 16; a += 5) begin
      dbg_addr = a[3:0];
      #1;
      n_checks++;
      if (dbg_state !== 11'd0) $display("FAIL reset_dbg[%0d]: got %h want 0", a, dbg_state);
      else n_pass++;
    end
  endtask

  task automatic test_exc_inh();
    pk_t obs;
    pk_t e;
    logic rdy;
    param_fi_sel = 3'd0; param_leak_en = 1'b1; param_leak_str = 7'd2;
    issue(1, 5, 6, obs, rdy);
    n_checks++;
    if (obs !== pk(1, 5, 6, 0, 0, 0) || rdy !== 1'b1)
      $display("FAIL exc_first: got %h ready=%b want %h ready=1", obs, rdy, pk(1, 5, 6, 0, 0, 0));
    else n_pass++;
    issue(1, 5, 3, obs, rdy);
`ifdef IZH_INACC_OVFL_CLR_EN
    e = pk(1, 5, 0, 0, 1, 0);
`else
    e = pk(1, 5, 9, 0, 1, 0);
`endif
    n_checks++;
    if (obs !== e) $display("FAIL exc_second_ovfl: got %h want %h", obs, e);
    else n_pass++;
    dbg_addr = 4'd5;
    #1;
    n_checks++;
    if (dbg_state !== e[13:3]) $display("FAIL exc_dbg: got %h want %h", dbg_state, e[13:3]);
    else n_pass++;
    issue(2, 2, 1, obs, rdy);
`ifdef IZH_INACC_OVFL_CLR_EN
    e = pk(1, 2, 'h7F0, 0, 0, 1);
`else
    e = pk(1, 2, 'h7FF, 0, 0, 1);
`endif
    n_checks++;
    if (obs !== e) $display("FAIL inh_underflow: got %h want %h", obs, e);
    else n_pass++;
  endtask

  task automatic test_leak_clear();
    pk_t obs;
    pk_t e;
    logic rdy;
    param_fi_sel = 3'd0; param_leak_str = 7'd2; param_leak_en = 1'b1;
    issue(3, 3, 0, obs, rdy);
    issue(1, 3, 1, obs, rdy);
    issue(0, 3, 0, obs, rdy);
`ifdef IZH_INACC_OVFL_CLR_EN
    e = pk(1, 3, 'h7F0, 1, 0, 0);
`else
    e = pk(1, 3, 'h7FF, 1, 0, 0);
`endif
    n_checks++;
    if (obs !== e) $display("FAIL leak_enabled: got %h want %h", obs, e);
    else n_pass++;
    param_leak_en = 1'b0;
    issue(0, 3, 0, obs, rdy);
    e = {e[18:3], 3'b000};
    n_checks++;
    if (obs !== e) $display("FAIL leak_disabled: got %h want %h", obs, e);
    else n_pass++;
    // bit 10 is set in the stored value, so an ungated clear would flag
    param_fi_sel = 3'd7;
    issue(3, 3, 0, obs, rdy);
    n_checks++;
    if (obs !== pk(1, 3, 0, 0, 0, 0)) $display("FAIL clear_event: got %h want %h", obs, pk(1, 3, 0, 0, 0, 0));
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    pk_t exp_at [0:41];
    bit  exp_v  [0:41];
    for (int b = 0; b < 3; b++) begin
      param_leak_str = 7'($urandom_range(0, 127));
      param_leak_en  = 1'($urandom_range(0, 1));
      param_fi_sel   = 3'($urandom_range(0, 7));
      for (int c = 0; c < 42; c++) exp_v[c] = 1'b0;
      for (int c = 0; c < 42; c++) begin
        @(negedge CLK);
        n_checks++;
        if (exp_v[c]) begin
          if (obs_now() !== exp_at[c]) $display("FAIL b2b[%0d.%0d]: got %h want %h", b, c, obs_now(), exp_at[c]);
          else n_pass++;
        end else begin
          if (out_valid !== 1'b0) $display("FAIL b2b_idle[%0d.%0d]: got valid=%b want 0", b, c, out_valid);
          else n_pass++;
        end
        if (c < 40 && $urandom_range(0, 9) < 7) begin
          int t, a, w, n;
          bit f;
          t = $urandom_range(0, 3);
          a = $urandom_range(0, 3);
          w = $urandom_range(0, 7);
          ev_valid = 1'b1; ev_type = t[1:0]; ev_addr = a[3:0]; ev_weight = w[2:0];
          model_op(t, mdl[a], w, int'(param_leak_str), param_leak_en, int'(param_fi_sel), 11, n, f);
          mdl[a] = n;
          exp_v[c+2]  = 1'b1;
          exp_at[c+2] = pk(1, a, n, f && t == 0, f && t == 1, f && t == 2);
        end else begin
          ev_valid = 1'b0;
        end
      end
      for (int a = 0; a < 4; a++) begin
        dbg_addr = a[3:0];
        #1;
        n_checks++;
        if (int'(dbg_state) !== mdl[a]) $display("FAIL b2b_dbg[%0d]: got %h want %h", a, dbg_state, mdl[a]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_fanin_top();
    pk_t obs;
    pk_t e;
    logic rdy;
    int n;
    bit f;
    param_fi_sel = 3'd7; param_leak_en = 1'b0;
    issue(3, 9, 0, obs, rdy);
    for (int j = 0; j < 147; j++) begin
      int w;
      w = (j < 146) ? 7 : 1;
      @(negedge CLK);
      ev_valid = 1'b1; ev_type = 2'd1; ev_addr = 4'd9; ev_weight = w[2:0];
      model_op(1, mdl[9], w, 0, 1'b0, 7, 11, n, f);
      mdl[9] = n;
    end
    @(negedge CLK);
    ev_valid = 1'b0;
    @(negedge CLK);
    n_checks++;
    if (obs_now() !== pk(1, 9, 1023, 0, 0, 0)) $display("FAIL fanin11_build: got %h want %h", obs_now(), pk(1, 9, 1023, 0, 0, 0));
    else n_pass++;
    issue(1, 9, 1, obs, rdy);
`ifdef IZH_INACC_OVFL_CLR_EN
    e = pk(1, 9, 0, 0, 1, 0);
`else
    e = pk(1, 9, 1024, 0, 1, 0);
`endif
    n_checks++;
    if (obs !== e) $display("FAIL fanin11_ovfl: got %h want %h", obs, e);
    else n_pass++;
  endtask

  task automatic test_fanin_narrow();
    logic [12:0] e;
    param_fi_sel = 3'd7;
    for (int j = 0; j < 20; j++) begin
      int w;
      w = (j == 19) ? 1 : 7;
      @(negedge CLK);
      if (j == 0) begin
        n_checks++;
        if (b_ev_ready !== 1'b1) $display("FAIL fanin8_ready: got %b want 1", b_ev_ready);
        else n_pass++;
      end
      b_ev_valid = 1'b1; b_ev_addr = 1'b0; b_ev_weight = w[2:0];
      b_ev_type = (j == 0) ? 2'd3 : 2'd1;
    end
    @(negedge CLK);
    b_ev_valid = 1'b0;
    @(negedge CLK);
    n_checks++;
    if ({b_out_valid, b_out_addr, b_out_state, b_ovfl_leak, b_ovfl_exc, b_ovfl_inh} !== {1'b1, 1'b0, 8'd127, 3'b000})
      $display("FAIL fanin8_build: got valid=%b state=%0d flags=%b%b%b want 1/127/000",
               b_out_valid, b_out_state, b_ovfl_leak, b_ovfl_exc, b_ovfl_inh);
    else n_pass++;
    @(negedge CLK);
    b_ev_valid = 1'b1; b_ev_type = 2'd1; b_ev_weight = 3'd1;
    @(negedge CLK);
    b_ev_valid = 1'b0;
    @(negedge CLK);
`ifdef IZH_INACC_OVFL_CLR_EN
    e = {1'b1, 1'b0, 8'd0, 3'b010};
`else
    e = {1'b1, 1'b0, 8'd128, 3'b010};
`endif
    n_checks++;
    if ({b_out_valid, b_out_addr, b_out_state, b_ovfl_leak, b_ovfl_exc, b_ovfl_inh} !== e)
      $display("FAIL fanin8_ovfl: got %h want %h",
               {b_out_valid, b_out_addr, b_out_state, b_ovfl_leak, b_ovfl_exc, b_ovfl_inh}, e);
    else n_pass++;
    b_dbg_addr = 1'b0;
    #1;
    n_checks++;
    if (b_dbg_state !== e[10:3]) $display("FAIL fanin8_dbg: got %0d want %0d", b_dbg_state, e[10:3]);
    else n_pass++;
  endtask

  task automatic test_leak_sweep();
    pk_t e [16];
    int low_cnt;
    int n;
    bit f;
    param_leak_str = 7'($urandom_range(1, 127));
    param_leak_en  = 1'b1;
    param_fi_sel   = 3'($urandom_range(0, 7));
    for (int i = 0; i < 16; i++) begin
      model_op(0, mdl[i], 0, int'(param_leak_str), 1'b1, int'(param_fi_sel), 11, n, f);
      mdl[i] = n;
      e[i] = pk(1, i, n, f, 0, 0);
    end
    low_cnt = 0;
    @(negedge CLK);
    leak_all = 1'b1;
    ev_valid = 1'b1; ev_type = 2'd1; ev_addr = 4'd0; ev_weight = 3'd7;
    #1;
    if (ev_ready === 1'b0) low_cnt++;
    @(negedge CLK);
    leak_all = 1'b0;
    if (ev_ready === 1'b0) low_cnt++;
    for (int i = 0; i < 16; i++) begin
      @(negedge CLK);
      n_checks++;
      if (obs_now() !== e[i]) $display("FAIL sweep_leak[%0d]: got %h want %h", i, obs_now(), e[i]);
      else n_pass++;
      if (i < 15) begin
        if (ev_ready === 1'b0) low_cnt++;
      end else begin
        n_checks++;
        if (ev_ready !== 1'b1) $display("FAIL sweep_ready_back: got %b want 1", ev_ready);
        else n_pass++;
        ev_valid = 1'b0;
      end
    end
    n_checks++;
    if (low_cnt !== 17) $display("FAIL sweep_ready_low_cycles: got %0d want 17", low_cnt);
    else n_pass++;
    @(negedge CLK);
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL sweep_no_extra: got valid=%b want 0", out_valid);
    else n_pass++;
    for (int a = 0; a < 16; a++) begin
      dbg_addr = a[3:0];
      #1;
      n_checks++;
      if (int'(dbg_state) !== mdl[a]) $display("FAIL sweep_dbg[%0d]: got %h want %h", a, dbg_state, mdl[a]);
      else n_pass++;
    end
  endtask

  task automatic test_clr_reset();
    pk_t obs;
    logic rdy;
    param_fi_sel = 3'd7;
    for (int a = 0; a < 16; a++) issue(1, a, $urandom_range(1, 7), obs, rdy);
    @(negedge CLK);
    clr_all = 1'b1; leak_all = 1'b1;
    #1;
    n_checks++;
    if (ev_ready !== 1'b0) $display("FAIL clr_req_ready: got %b want 0", ev_ready);
    else n_pass++;
    @(negedge CLK);
    clr_all = 1'b0; leak_all = 1'b0;
    for (int i = 0; i < 7; i++) begin
      @(negedge CLK);
      n_checks++;
      if (out_valid !== 1'b0) $display("FAIL clr_sweep_valid[%0d]: got %b want 0", i, out_valid);
      else n_pass++;
      dbg_addr = i[3:0];
      #1;
      n_checks++;
      if (dbg_state !== 11'd0) $display("FAIL clr_sweep_done[%0d]: got %h want 0", i, dbg_state);
      else n_pass++;
      dbg_addr = 4'(i + 1);
      #1;
      n_checks++;
      if (int'(dbg_state) !== mdl[i+1]) $display("FAIL clr_sweep_ahead[%0d]: got %h want %h", i + 1, dbg_state, mdl[i+1]);
      else n_pass++;
      if (i == 6) RST = 1'b1;
    end
    @(negedge CLK);
    n_checks++;
    if ({out_valid, ev_ready} !== 2'b00) $display("FAIL clr_rst_state: got valid=%b ready=%b want 0 0", out_valid, ev_ready);
    else n_pass++;
    RST = 1'b0;
    foreach (mdl[i]) mdl[i] = 0;
    @(negedge CLK);
    n_checks++;
    if ({out_valid, ev_ready} !== 2'b01) $display("FAIL clr_after_rst: got valid=%b ready=%b want 0 1", out_valid, ev_ready);
    else n_pass++;
    for (int a = 0; a < 16; a++) begin
      dbg_addr = a[3:0];
      #1;
      n_checks++;
      if (dbg_state !== 11'd0) $display("FAIL clr_rst_dbg[%0d]: got %h want 0", a, dbg_state);
      else n_pass++;
    end
    @(negedge CLK);
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL clr_rst_quiet: got valid=%b want 0", out_valid);
    else n_pass++;
  endtask

  initial begin
    RST = 1'b1;
    param_leak_str = 7'd0; param_leak_en = 1'b0; param_fi_sel = 3'd0;
    ev_valid = 1'b0; ev_type = 2'd0; ev_addr = 4'd0; ev_weight = 3'd0;
    leak_all = 1'b0; clr_all = 1'b0; dbg_addr = 4'd0;
    b_ev_valid = 1'b0; b_ev_type = 2'd0; b_ev_addr = 1'b0; b_ev_weight = 3'd0; b_dbg_addr = 1'b0;
    do_reset();
    test_reset();
    test_exc_inh();
    test_leak_clear();
    test_back_to_back();
    test_fanin_top();
    test_fanin_narrow();
    test_leak_sweep();
    test_clr_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
